// File: rtl/fp_issue_pkg.sv
// Shared types for the FP add/sub issue controller.
package fp_issue_pkg;

  // Quiet NaN returned when the unit never answers.
  localparam logic [31:0] FP_QNAN  = 32'h7FC00000;

  // Default tag width carried through the op record.
  localparam int unsigned OP_TAG_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  typedef struct packed {
    logic [31:0]         a;
    logic [31:0]         b;
    logic                sub;
    logic [OP_TAG_W-1:0] tag;
  } op_t;

endpackage

// File: rtl/fp_wait_timer.sv
// Saturating cycle counter with a terminal flag at MAX_WAIT.
module fp_wait_timer #(
  parameter int unsigned LAT_W    = 8,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [LAT_W-1:0] o_count,
  output logic             o_term
);

  logic [LAT_W-1:0] r_count;

  // Clear wins over enable; the count holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count >= LAT_W'(MAX_WAIT));

endmodule

// File: rtl/fp_addsub_issue_ctrl.sv
// Start/done initiator for the multi-cycle FP add/sub unit with a tagged
// CDB-style result port, latency measurement, flush and timeout handling.
module fp_addsub_issue_ctrl
  import fp_issue_pkg::*;
#(
  parameter int unsigned TAG_W    = OP_TAG_W,
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned LAT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rs_valid,
  output logic             rs_ready,
  input  logic [31:0]      rs_a,
  input  logic [31:0]      rs_b,
  input  logic             rs_sub,
  input  logic [TAG_W-1:0] rs_tag,
  input  logic             flush,
  output logic             fu_start,
  output logic [31:0]      fu_a_operand,
  output logic [31:0]      fu_b_operand,
  output logic             fu_addbar_sub,
  input  logic             fu_done,
  input  logic [31:0]      fu_result,
  input  logic             fu_exception,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_result,
  output logic             cdb_exception,
  output logic             cdb_timeout,
  output logic [LAT_W-1:0] cdb_latency
);

  state_t           r_state;
  state_t           w_next;
  op_t              r_op;
  logic [31:0]      r_cdb_result;
  logic             r_cdb_exception;
  logic             r_cdb_timeout;
  logic [LAT_W-1:0] r_cdb_latency;

  logic             w_accept;
  logic             w_capture;
  logic             w_timeout;
  logic             w_tmr_clear;
  logic             w_tmr_enable;
  logic [LAT_W-1:0] w_count;
  logic             w_term;

  // The counter runs through ISSUE so it already reads 1 in the first WAIT cycle.
  fp_wait_timer #(
    .LAT_W   (LAT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_tmr_clear),
    .i_enable(w_tmr_enable),
    .o_count (w_count),
    .o_term  (w_term)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, handshake outputs and datapath load strobes.
  always_comb begin
    w_next       = r_state;
    rs_ready     = 1'b0;
    fu_start     = 1'b0;
    cdb_valid    = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_tmr_clear  = 1'b0;
    w_tmr_enable = 1'b0;
    unique case (r_state)
      IDLE: begin
        rs_ready    = 1'b1;
        w_tmr_clear = 1'b1;
        if (rs_valid && !flush) begin
          w_accept = 1'b1;
          w_next   = ISSUE;
        end
      end
      ISSUE: begin
        fu_start     = 1'b1;
        w_tmr_enable = 1'b1;
        w_next       = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        w_tmr_enable = 1'b1;
        // A flush in the same cycle the unit finishes has nothing left to drain.
        if (flush) begin
          w_next = (fu_done || w_term) ? IDLE : DRAIN;
        end else if (fu_done) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end else if (w_term) begin
          w_timeout = 1'b1;
          w_next    = RESP;
        end
      end
      RESP: begin
        cdb_valid   = 1'b1;
        w_tmr_clear = 1'b1;
        if (flush || cdb_ready) begin
          w_next = IDLE;
        end
      end
      DRAIN: begin
        w_tmr_enable = 1'b1;
        if (fu_done || w_term) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Op register: loaded only on accept, so operands hold until the next op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= '0;
    end else if (w_accept) begin
      r_op.a   <= rs_a;
      r_op.b   <= rs_b;
      r_op.sub <= rs_sub;
      r_op.tag <= OP_TAG_W'(rs_tag);
    end
  end

  // Result registers: real result on done, synthesised QNaN on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb_result    <= '0;
      r_cdb_exception <= 1'b0;
      r_cdb_timeout   <= 1'b0;
      r_cdb_latency   <= '0;
    end else if (w_capture) begin
      r_cdb_result    <= fu_result;
      r_cdb_exception <= fu_exception;
      r_cdb_timeout   <= 1'b0;
      r_cdb_latency   <= w_count;
    end else if (w_timeout) begin
      r_cdb_result    <= FP_QNAN;
      r_cdb_exception <= 1'b1;
      r_cdb_timeout   <= 1'b1;
      r_cdb_latency   <= w_count;
    end
  end

  assign fu_a_operand  = r_op.a;
  assign fu_b_operand  = r_op.b;
  assign fu_addbar_sub = r_op.sub;
  assign cdb_tag       = TAG_W'(r_op.tag);
  assign cdb_result    = r_cdb_result;
  assign cdb_exception = r_cdb_exception;
  assign cdb_timeout   = r_cdb_timeout;
  assign cdb_latency   = r_cdb_latency;

endmodule

// File: tb/tb_fp_addsub_issue_ctrl.sv
// Directed bench for fp_addsub_issue_ctrl with a delay-programmable FU model
// and a queue of expected CDB responses.
module tb_fp_addsub_issue_ctrl;

  localparam int unsigned TAG_W    = 4;
  localparam int unsigned MAX_WAIT = 64;
  localparam int unsigned LAT_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rs_valid = 1'b0;
  logic             rs_ready;
  logic [31:0]      rs_a = '0;
  logic [31:0]      rs_b = '0;
  logic             rs_sub = 1'b0;
  logic [TAG_W-1:0] rs_tag = '0;
  logic             flush = 1'b0;
  logic             fu_start;
  logic [31:0]      fu_a_operand;
  logic [31:0]      fu_b_operand;
  logic             fu_addbar_sub;
  logic             fu_done;
  logic [31:0]      fu_result;
  logic             fu_exception;
  logic             cdb_valid;
  logic             cdb_ready = 1'b0;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_result;
  logic             cdb_exception;
  logic             cdb_timeout;
  logic [LAT_W-1:0] cdb_latency;

  fp_addsub_issue_ctrl #(
    .TAG_W   (TAG_W),
    .MAX_WAIT(MAX_WAIT),
    .LAT_W   (LAT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs_valid     (rs_valid),
    .rs_ready     (rs_ready),
    .rs_a         (rs_a),
    .rs_b         (rs_b),
    .rs_sub       (rs_sub),
    .rs_tag       (rs_tag),
    .flush        (flush),
    .fu_start     (fu_start),
    .fu_a_operand (fu_a_operand),
    .fu_b_operand (fu_b_operand),
    .fu_addbar_sub(fu_addbar_sub),
    .fu_done      (fu_done),
    .fu_result    (fu_result),
    .fu_exception (fu_exception),
    .cdb_valid    (cdb_valid),
    .cdb_ready    (cdb_ready),
    .cdb_tag      (cdb_tag),
    .cdb_result   (cdb_result),
    .cdb_exception(cdb_exception),
    .cdb_timeout  (cdb_timeout),
    .cdb_latency  (cdb_latency)
  );

  always #5 clk = ~clk;

  // FU model: raises done fu_delay cycles after the start cycle (0 = never).
  int          fu_delay = 0;
  int          fu_cnt;
  logic        fu_armed;
  logic        fu_force_done = 1'b0;
  logic [31:0] fu_res_m = '0;
  logic        fu_exc_m = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_armed <= 1'b0;
      fu_cnt   <= 0;
    end else if (fu_start) begin
      fu_armed <= 1'b1;
      fu_cnt   <= 1;
    end else if (fu_armed) begin
      if (fu_done) fu_armed <= 1'b0;
      else         fu_cnt   <= fu_cnt + 1;
    end
  end

  assign fu_done      = fu_force_done || (fu_armed && (fu_delay != 0) && (fu_cnt == fu_delay));
  assign fu_result    = fu_res_m;
  assign fu_exception = fu_exc_m;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic             exc;
    logic             tmo;
    logic [LAT_W-1:0] lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op in IDLE; returns at the sample point of the first WAIT cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [TAG_W-1:0] tag, input int dly,
                       input logic [31:0] res, input logic exc);
    chk("idle_rs_ready", rs_ready, 1);
    fu_delay = dly;
    fu_res_m = res;
    fu_exc_m = exc;
    rs_valid = 1'b1;
    rs_a     = a;
    rs_b     = b;
    rs_sub   = sub;
    rs_tag   = tag;
    tick();
    rs_valid = 1'b0;
    chk("start_high", fu_start, 1);
    chk("fu_a", fu_a_operand, a);
    chk("fu_b", fu_b_operand, b);
    chk("fu_sub", fu_addbar_sub, sub);
    chk("rs_ready_busy", rs_ready, 0);
    tick();
    chk("start_one_cycle", fu_start, 0);
  endtask

  // Waits for cdb_valid, stalls the CDB for 'stall' cycles, then handshakes.
  task automatic collect(input int stall);
    int          n;
    exp_t        e;
    logic [31:0] held;
    n = 0;
    while (!cdb_valid && n < 200) begin
      tick();
      n++;
    end
    chk("cdb_valid_seen", cdb_valid, 1);
    if (cdb_valid) begin
      held = cdb_result;
      for (int i = 0; i < stall; i++) begin
        chk("stall_valid", cdb_valid, 1);
        chk("stall_hold", cdb_result, held);
        chk("stall_rs_ready", rs_ready, 0);
        chk("stall_no_start", fu_start, 0);
        tick();
      end
      rs_valid = 1'b0;
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("cdb_tag", cdb_tag, e.tag);
        chk("cdb_result", cdb_result, e.res);
        chk("cdb_exception", cdb_exception, e.exc);
        chk("cdb_timeout", cdb_timeout, e.tmo);
        chk("cdb_latency", cdb_latency, e.lat);
      end
      cdb_ready = 1'b1;
      tick();
      cdb_ready = 1'b0;
      chk("valid_drop", cdb_valid, 0);
      chk("rs_ready_back", rs_ready, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_rs_ready", rs_ready, 1);
    chk("rst_fu_start", fu_start, 0);
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_latency", cdb_latency, 0);
    chk("rst_fu_a", fu_a_operand, 0);
    chk("rst_cdb_result", cdb_result, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic add: 1.5 + 2.5 = 4.0, done at +3
    sb.push_back('{4'd3, 32'h40800000, 1'b0, 1'b0, 8'd3});
    issue(32'h3FC00000, 32'h40200000, 1'b0, 4'd3, 3, 32'h40800000, 1'b0);
    collect(0);

    // Sub with backpressure while the RS presents another op
    sb.push_back('{4'd5, 32'h40800000, 1'b0, 1'b0, 8'd2});
    issue(32'h40B00000, 32'h3FC00000, 1'b1, 4'd5, 2, 32'h40800000, 1'b0);
    rs_valid = 1'b1;
    rs_a     = 32'h11111111;
    collect(5);
    chk("no_early_accept", fu_start, 0);

    // Exception passthrough
    sb.push_back('{4'd9, 32'h7F800000, 1'b1, 1'b0, 8'd5});
    issue(32'h7F800000, 32'h40000000, 1'b0, 4'd9, 5, 32'h7F800000, 1'b1);
    collect(0);

    // Timeout: unit never answers
    sb.push_back('{4'd12, 32'h7FC00000, 1'b1, 1'b1, 8'(MAX_WAIT)});
    issue(32'h3F800000, 32'h3F800000, 1'b0, 4'd12, 0, 32'hDEADBEEF, 1'b0);
    collect(0);

    // Flush one cycle after start, unit done at +4
    issue(32'h40400000, 32'h40400000, 1'b0, 4'd7, 4, 32'h40C00000, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_no_valid", cdb_valid, 0);
    tick();
    chk("drain_busy_t3", rs_ready, 0);
    tick();
    chk("drain_busy_t4", rs_ready, 0);
    chk("drain_no_valid2", cdb_valid, 0);
    tick();
    chk("drain_release", rs_ready, 1);
    chk("drain_no_valid3", cdb_valid, 0);
    sb.push_back('{4'd1, 32'h40000000, 1'b0, 1'b0, 8'd2});
    issue(32'h3F800000, 32'h3F800000, 1'b0, 4'd1, 2, 32'h40000000, 1'b0);
    collect(0);

    // Flush in IDLE blocks a same-cycle op
    rs_valid = 1'b1;
    flush    = 1'b1;
    tick();
    rs_valid = 1'b0;
    flush    = 1'b0;
    chk("idle_flush_no_start", fu_start, 0);
    chk("idle_flush_ready", rs_ready, 1);

    // Flush in RESP drops the result
    issue(32'h40000000, 32'h40000000, 1'b0, 4'd2, 2, 32'h40800000, 1'b0);
    for (int i = 0; i < 10 && !cdb_valid; i++) tick();
    chk("resp_flush_valid", cdb_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("resp_flush_drop", cdb_valid, 0);
    chk("resp_flush_ready", rs_ready, 1);

    // Asynchronous reset mid-WAIT, then a stale done in IDLE
    issue(32'h40A00000, 32'h3F800000, 1'b0, 4'd4, 0, 32'h40C00000, 1'b0);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_fu_start", fu_start, 0);
    chk("arst_cdb_valid", cdb_valid, 0);
    chk("arst_latency", cdb_latency, 0);
    chk("arst_rs_ready", rs_ready, 1);
    chk("arst_fu_a", fu_a_operand, 0);
    tick();
    rst_n = 1'b1;
    tick();
    fu_force_done = 1'b1;
    tick();
    fu_force_done = 1'b0;
    chk("stale_done_valid", cdb_valid, 0);
    chk("stale_done_start", fu_start, 0);
    chk("stale_done_ready", rs_ready, 1);
    tick();
    chk("stale_done_valid2", cdb_valid, 0);

    // Normal op after reset
    sb.push_back('{4'd6, 32'h40400000, 1'b0, 1'b0, 8'd1});
    issue(32'h3F800000, 32'h40000000, 1'b0, 4'd6, 1, 32'h40400000, 1'b0);
    collect(0);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
